uart_rx_deser: RTL and testbench



---
 rtl/uart_rx_deser.sv | 193 +++++++++++++++++++
 tb/tb_uart_rx_deser.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deser.sv
// rtl/uart_rx_deser.sv - 8N1 UART receiver with a valid/ready byte output, framing-error and overrun flags
// Optional UART_RX_MAJORITY_EN: each bit decision is a 2-of-3 vote around the sample point, one clock later
module uart_rx_deser #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rs232_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int BIT_CYC  = CLK_FREQ / BAUD;
    localparam int HALF_CYC = BIT_CYC / 2;
    localparam int CW       = (BIT_CYC > 2) ? $clog2(BIT_CYC) : 1;

    localparam logic [CW-1:0] BIT_TERM  = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] HALF_TERM = CW'(HALF_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_DELIVER,
        S_BREAK
    } state_t;

    state_t          state_q, state_d;
    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            sync3_q, sync3_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            rx_busy_q, rx_busy_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q, overrun_d;

    logic            start_edge;
    logic            tick;
    logic            decide;
    logic            sample;
    logic            handshake;
    logic [CW-1:0]   term;

`ifdef UART_RX_MAJORITY_EN
    logic            hist1_q, hist1_d;
    logic            hist2_q, hist2_d;
    logic            tick_q, tick_d;
`endif

    always_comb begin
        sync1_d     = rs232_rx;
        sync2_d     = sync1_q;
        sync3_d     = sync2_q;
        start_edge  = sync3_q & ~sync2_q;

        term = (state_q == S_START) ? HALF_TERM : BIT_TERM;
        tick = (state_q inside {S_START, S_DATA, S_STOP}) && (cnt_q == term);

`ifdef UART_RX_MAJORITY_EN
        // Decision is taken the cycle after the terminal count, voting over terminal-1..terminal+1
        hist1_d = sync2_q;
        hist2_d = hist1_q;
        tick_d  = tick;
        decide  = tick_q;
        sample  = (hist2_q & hist1_q) | (hist2_q & sync2_q) | (hist1_q & sync2_q);
`else
        decide  = tick;
        sample  = sync2_q;
`endif

        if (state_q inside {S_START, S_DATA, S_STOP}) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end else begin
            cnt_d = '0;
        end

        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_edge) state_d = S_START;
            end
            S_START: begin
                if (decide) begin
                    bit_idx_d = 3'd0;
                    state_d   = sample ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (decide) begin
                    shift_d   = {sample, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (decide) begin
                    if (sample) begin
                        state_d = S_DELIVER;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end
            end
            S_DELIVER: state_d = S_IDLE;
            S_BREAK: begin
                // Hold here until the line idles so a held-low line cannot look like a new start
                if (sync2_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        rx_busy_d = (state_d != S_IDLE);

        handshake  = rx_valid_q & rx_ready;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = overrun_q;
        if (handshake) begin
            rx_valid_d = 1'b0;
            overrun_d  = 1'b0;
        end
        if (state_q == S_DELIVER) begin
            if (!rx_valid_q || handshake) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            sync3_q     <= 1'b1;
            cnt_q       <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'd0;
            rx_data_q   <= 8'd0;
            rx_valid_q  <= 1'b0;
            rx_busy_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
            hist1_q     <= 1'b1;
            hist2_q     <= 1'b1;
            tick_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            sync3_q     <= sync3_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_busy_q   <= rx_busy_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_MAJORITY_EN
            hist1_q     <= hist1_d;
            hist2_q     <= hist2_d;
            tick_q      <= tick_d;
`endif
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign rx_busy   = rx_busy_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_deser.sv
// tb/tb_uart_rx_deser.sv - self-checking bench for uart_rx_deser with a byte/error scoreboard model
module tb_uart_rx_deser;

    localparam int CLK_FREQ = 1600;
    localparam int BAUD     = 100;
    localparam int BIT      = CLK_FREQ / BAUD;
    localparam int HALF     = BIT / 2;
    localparam int LAT      = 3 + HALF + 9 * BIT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rs232_rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun;

    uart_rx_deser #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rs232_rx  (rs232_rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_busy   (rx_busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_cmp = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];
    int         err_exp = 0;
    int         rise_cyc = -1;
    int         fall_cyc = 0;
    int         busy_cnt = 0;
    logic       prev_valid = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Scoreboard: every consumed byte must be the next expected good frame, every error pulse expected
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (rx_valid && !prev_valid) rise_cyc = cyc;
            prev_valid = rx_valid;
            if (rx_busy) busy_cnt++;
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got %0d, expected none", rx_data);
                end else begin
                    check("rx_data", int'(rx_data), int'(exp_q.pop_front()));
                end
            end
            if (frame_err) begin
                n_cmp++;
                if (err_exp == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_frame_err: got 1, expected 0");
                end else begin
                    err_exp--;
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rs232_rx = 1'b0;
        fall_cyc = cyc;
        wait_cyc(BIT);
        for (int i = 0; i < 8; i++) begin
            rs232_rx = b[i];
            wait_cyc(BIT);
        end
        rs232_rx = stop;
        wait_cyc(BIT);
    endtask

    task automatic good_frame(input logic [7:0] b);
        exp_q.push_back(b);
        send_frame(b, 1'b1);
    endtask

    task automatic drain_check(input string tag);
        check({tag, "_pending_bytes"}, exp_q.size(), 0);
        check({tag, "_pending_errs"}, err_exp, 0);
    endtask

    initial begin
        logic [7:0] rb;
        wait_cyc(3);
        check("reset_rx_valid", int'(rx_valid), 0);
        check("reset_rx_busy", int'(rx_busy), 0);
        check("reset_rx_data", int'(rx_data), 0);
        check("reset_frame_err", int'(frame_err), 0);
        check("reset_overrun", int'(overrun), 0);
        rst_n = 1'b1;
        wait_cyc(2 * BIT);

        rx_ready = 1'b1;
        rise_cyc = -1;
        good_frame(8'hA5);
        wait_cyc(BIT);
        check_range("latency_a5", rise_cyc - fall_cyc, LAT - 1, LAT + 2);
        check("a5_overrun", int'(overrun), 0);
        drain_check("a5");

        good_frame(8'h00);
        good_frame(8'hFF);
        good_frame(8'h55);
        wait_cyc(2 * BIT);
        drain_check("b2b");

        busy_cnt = 0;
        rs232_rx = 1'b0;
        wait_cyc(HALF / 2);
        rs232_rx = 1'b1;
        wait_cyc(2 * BIT);
        check_range("glitch_busy_cycles", busy_cnt, HALF - 1, HALF + 3);
        drain_check("glitch");

        err_exp++;
        send_frame(8'h3C, 1'b0);
        wait_cyc(BIT);
        check("break_busy_while_low", int'(rx_busy), 1);
        check("break_no_valid", int'(rx_valid), 0);
        rs232_rx = 1'b1;
        wait_cyc(4);
        check("break_idle_after_high", int'(rx_busy), 0);
        wait_cyc(BIT);
        drain_check("ferr");

        rx_ready = 1'b0;
        good_frame(8'h11);
        wait_cyc(2);
        check("ovr_first_valid", int'(rx_valid), 1);
        check("ovr_first_data", int'(rx_data), 8'h11);
        check("ovr_first_flag", int'(overrun), 0);
        send_frame(8'h22, 1'b1);
        wait_cyc(2);
        check("ovr_second_valid", int'(rx_valid), 1);
        check("ovr_second_data", int'(rx_data), 8'h11);
        check("ovr_second_flag", int'(overrun), 1);
        rx_ready = 1'b1;
        wait_cyc(1);
        rx_ready = 1'b0;
        check("ovr_after_hs_valid", int'(rx_valid), 0);
        check("ovr_after_hs_flag", int'(overrun), 0);
        drain_check("ovr");

        rx_ready = 1'b1;
        rb = 8'h81;
        rs232_rx = 1'b0;
        wait_cyc(BIT);
        for (int i = 0; i < 4; i++) begin
            rs232_rx = rb[i];
            wait_cyc(BIT);
        end
        rs232_rx = rb[4];
        wait_cyc(HALF);
        rst_n = 1'b0;
        rs232_rx = 1'b1;
        wait_cyc(2);
        check("midrst_busy", int'(rx_busy), 0);
        check("midrst_valid", int'(rx_valid), 0);
        rst_n = 1'b1;
        wait_cyc(2 * BIT);
        good_frame(8'h7E);
        wait_cyc(2 * BIT);
        drain_check("midrst");

        for (int f = 0; f < 16; f++) begin
            rb = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                err_exp++;
                send_frame(rb, 1'b0);
                wait_cyc($urandom_range(0, 2) * BIT);
                rs232_rx = 1'b1;
                wait_cyc(BIT + $urandom_range(0, BIT));
            end else begin
                good_frame(rb);
                wait_cyc($urandom_range(0, 2 * BIT));
            end
        end
        wait_cyc(2 * BIT);
        drain_check("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
